// File: rtl/vc_arb_pkg.sv
// Shared types and helpers for the vector-lane arbiters.
// Pure declarations; no timing or flow-control behaviour of its own.
package vc_arb_pkg;

  localparam int ARB_MAX_N     = 64;
  localparam int ARB_MAX_IDX_W = 6;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // OR-reduction form: a zero vector maps to index 0.
  function automatic logic [ARB_MAX_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    logic [ARB_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | ARB_MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_p.sv
// Fixed-priority arbiter: lowest set request bit wins, purely combinational.
// Zero latency; no flow control, an empty request vector yields an empty grant.
module arbiter_p #(
  parameter int VECTOR_IN = 8
) (
  input  logic [VECTOR_IN-1:0] req,
  output logic [VECTOR_IN-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < VECTOR_IN; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_lock.sv
// Round-robin arbiter that locks a grant until last beat, request drop or beat limit; 1-cycle request-to-grant.
// Beats advance only on resource_ready; release re-arbitrates in the same cycle for zero-bubble handover.
module arbiter_rr_lock
  import vc_arb_pkg::*;
#(
  parameter int VECTOR_IN = 8,
  parameter int MAX_BEATS = 16,
  parameter int IDX_W     = $clog2(VECTOR_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VECTOR_IN-1:0] request_vector,
  input  logic [VECTOR_IN-1:0] req_last,
  input  logic                 resource_ready,
  output logic [VECTOR_IN-1:0] grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 beat_fire,
  output logic                 timeout_release
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t           state_q, state_d;
  logic [VECTOR_IN-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 timeout_q, timeout_d;

  logic [IDX_W-1:0]     ptr_wrap, arb_ptr, win_idx;
  logic [VECTOR_IN-1:0] arb_req, mask, masked_gnt, unmasked_gnt, win;
  logic                 rel_abandon, rel_last, rel_limit, rel_any;

  assign grant_valid     = |grant_q;
  assign grant           = grant_q;
  assign grant_id        = grant_id_q;
  assign timeout_release = timeout_q;
  assign beat_fire       = grant_valid & request_vector[grant_id_q] & resource_ready;

  assign rel_abandon = ~request_vector[grant_id_q];
  assign rel_last    = beat_fire & req_last[grant_id_q];
  assign rel_limit   = beat_fire & (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  assign rel_any     = rel_abandon | rel_last | rel_limit;

  assign ptr_wrap = (grant_id_q == IDX_W'(VECTOR_IN - 1)) ? '0 : grant_id_q + IDX_W'(1);

  // On release the pointer moves past the holder and the holder sits out this arbitration.
  assign arb_ptr = (state_q == ARB_LOCKED) ? ptr_wrap : rr_ptr_q;
  assign arb_req = request_vector & ~grant_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < VECTOR_IN; i++) begin
      mask[i] = (IDX_W'(i) >= arb_ptr);
    end
  end

  arbiter_p #(.VECTOR_IN(VECTOR_IN)) u_arb_masked (
    .req (arb_req & mask),
    .gnt (masked_gnt)
  );

  arbiter_p #(.VECTOR_IN(VECTOR_IN)) u_arb_unmasked (
    .req (arb_req),
    .gnt (unmasked_gnt)
  );

  assign win     = (|masked_gnt) ? masked_gnt : unmasked_gnt;
  assign win_idx = IDX_W'(onehot_to_idx(ARB_MAX_N'(win)));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|arb_req) begin
          grant_d    = win;
          grant_id_d = win_idx;
          state_d    = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (rel_any) begin
          rr_ptr_d   = ptr_wrap;
          beat_cnt_d = '0;
          timeout_d  = rel_limit & ~rel_last;
          if (|arb_req) begin
            grant_d    = win;
            grant_id_d = win_idx;
          end else begin
            grant_d    = '0;
            grant_id_d = '0;
            state_d    = ARB_IDLE;
          end
        end else if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_grant_id_match: assert property (@(posedge clk) disable iff (rst)
    grant_id_q == IDX_W'(onehot_to_idx(ARB_MAX_N'(grant_q))));
  a_grant_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB_LOCKED && !rel_any) |=> $stable(grant_q));

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// Bench for arbiter_rr_lock: directed scenarios plus a randomized run against a rotation model.
module tb_arbiter_rr_lock;

  localparam int N    = 8;
  localparam int MAXB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] request_vector = '0;
  logic [7:0] req_last = '0;
  logic       resource_ready = 1'b0;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       beat_fire;
  logic       timeout_release;

  int errors = 0;
  int checks = 0;

  // Reference model: current owner (-1 when idle), rotation start, accepted beats, pending pulse.
  int   m_owner;
  int   m_ptr;
  int   m_beats;
  logic m_tmo;

  always #5 clk = ~clk;

  arbiter_rr_lock #(.VECTOR_IN(N), .MAX_BEATS(MAXB)) dut (
    .clk             (clk),
    .rst             (rst),
    .request_vector  (request_vector),
    .req_last        (req_last),
    .resource_ready  (resource_ready),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id),
    .beat_fire       (beat_fire),
    .timeout_release (timeout_release)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    request_vector = '0;
    req_last = '0;
    resource_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int rr_pick(input logic [7:0] rq, input int ptr, input int excl);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (rq[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic m_reset;
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic m_step(input logic r, input logic [7:0] rq, input logic [7:0] lst, input logic rdy);
    logic fire;
    logic rel;
    if (r) begin
      m_reset();
    end else begin
      m_tmo = 1'b0;
      if (m_owner < 0) begin
        m_owner = rr_pick(rq, m_ptr, -1);
      end else begin
        fire = rq[m_owner] && rdy;
        rel  = 1'b0;
        if (!rq[m_owner]) rel = 1'b1;
        else if (fire && lst[m_owner]) rel = 1'b1;
        else if (fire && (m_beats + 1 == MAXB)) begin
          rel   = 1'b1;
          m_tmo = 1'b1;
        end else if (fire) m_beats++;
        if (rel) begin
          m_ptr   = (m_owner + 1) % N;
          m_beats = 0;
          m_owner = rr_pick(rq, m_ptr, m_owner);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    request_vector = '0;
    req_last = '0;
    resource_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h want 00", grant); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (timeout_release !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_release); end
    checks++; if (dut.rr_ptr_q !== 3'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      checks++; if (grant !== 8'h00) begin errors++; $display("FAIL idle_grant: cycle %0d got %h want 00", i, grant); end
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL idle_grant_valid: cycle %0d got %b want 0", i, grant_valid); end
      checks++; if (beat_fire !== 1'b0) begin errors++; $display("FAIL idle_beat_fire: cycle %0d got %b want 0", i, beat_fire); end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_g [6];
    exp_g = '{8'h01, 8'h04, 8'h80, 8'h01, 8'h04, 8'h80};
    do_reset();
    request_vector = 8'b1000_0101;
    req_last = 8'hFF;
    resource_ready = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 8'h00) begin errors++; $display("FAIL b2b_latency: got %h want 00", grant); end
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL b2b_grant: slot %0d got %h want %h", i, grant, exp_g[i]); end
      checks++; if (beat_fire !== 1'b1) begin errors++; $display("FAIL b2b_fire: slot %0d got %b want 1", i, beat_fire); end
      tick();
    end
    request_vector = '0;
    tick();
    tick();
  endtask

  task automatic test_ready_toggle;
    logic rdy [6];
    int fires;
    rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    fires = 0;
    do_reset();
    request_vector = 8'h08;
    tick();
    for (int i = 0; i < 6; i++) begin
      resource_ready = rdy[i];
      req_last = (i == 5) ? 8'h08 : 8'h00;
      @(negedge clk);
      checks++; if (grant !== 8'h08) begin errors++; $display("FAIL hold_grant: cycle %0d got %h want 08", i, grant); end
      checks++; if (beat_fire !== rdy[i]) begin errors++; $display("FAIL hold_fire: cycle %0d got %b want %b", i, beat_fire, rdy[i]); end
      if (beat_fire) fires++;
      tick();
    end
    checks++; if (fires != 4) begin errors++; $display("FAIL hold_fire_count: got %0d want 4", fires); end
    req_last = '0;
    resource_ready = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 8'h00) begin errors++; $display("FAIL sole_bubble: got %h want 00", grant); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h08) begin errors++; $display("FAIL sole_regrant: got %h want 08", grant); end
    request_vector = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    int pulses;
    pulses = 0;
    do_reset();
    request_vector = 8'h02;
    req_last = 8'h00;
    resource_ready = 1'b1;
    tick();
    request_vector = 8'h13;
    req_last = 8'h11;
    for (int k = 0; k < MAXB; k++) begin
      @(negedge clk);
      checks++; if (grant !== 8'h02) begin errors++; $display("FAIL tmo_hold: beat %0d got %h want 02", k, grant); end
      checks++; if (beat_fire !== 1'b1) begin errors++; $display("FAIL tmo_fire: beat %0d got %b want 1", k, beat_fire); end
      if (timeout_release) pulses++;
      tick();
    end
    @(negedge clk);
    checks++; if (grant !== 8'h10) begin errors++; $display("FAIL tmo_next: got %h want 10", grant); end
    checks++; if (timeout_release !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b want 1", timeout_release); end
    if (timeout_release) pulses++;
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h01) begin errors++; $display("FAIL tmo_rot0: got %h want 01", grant); end
    if (timeout_release) pulses++;
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h02) begin errors++; $display("FAIL tmo_regrant: got %h want 02", grant); end
    if (timeout_release) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL tmo_pulse_count: got %0d want 1", pulses); end
    request_vector = '0;
    tick();
    tick();
  endtask

  task automatic test_abandon;
    do_reset();
    request_vector = 8'h20;
    req_last = 8'h00;
    resource_ready = 1'b1;
    tick();
    request_vector = 8'h22;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (grant !== 8'h20) begin errors++; $display("FAIL abn_hold: beat %0d got %h want 20", i, grant); end
      checks++; if (beat_fire !== 1'b1) begin errors++; $display("FAIL abn_fire: beat %0d got %b want 1", i, beat_fire); end
      tick();
    end
    request_vector = 8'h02;
    @(negedge clk);
    checks++; if (beat_fire !== 1'b0) begin errors++; $display("FAIL abn_no_beat: got %b want 0", beat_fire); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h02) begin errors++; $display("FAIL abn_next: got %h want 02", grant); end
    checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL abn_next_id: got %0d want 1", grant_id); end
    checks++; if (dut.rr_ptr_q !== 3'd6) begin errors++; $display("FAIL abn_rr_ptr: got %0d want 6", dut.rr_ptr_q); end
    request_vector = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_midburst;
    do_reset();
    request_vector = 8'h30;
    req_last = 8'h10;
    resource_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h10) begin errors++; $display("FAIL mrst_first: got %h want 10", grant); end
    tick();
    req_last = 8'h00;
    @(negedge clk);
    checks++; if (grant !== 8'h20) begin errors++; $display("FAIL mrst_second: got %h want 20", grant); end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h00) begin errors++; $display("FAIL mrst_grant: got %h want 00", grant); end
    checks++; if (dut.rr_ptr_q !== 3'd0) begin errors++; $display("FAIL mrst_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
    checks++; if (timeout_release !== 1'b0) begin errors++; $display("FAIL mrst_timeout: got %b want 0", timeout_release); end
    rst = 1'b0;
    request_vector = 8'h48;
    tick();
    @(negedge clk);
    checks++; if (grant !== 8'h08) begin errors++; $display("FAIL mrst_regrant: got %h want 08", grant); end
    checks++; if (grant_id !== 3'd3) begin errors++; $display("FAIL mrst_regrant_id: got %0d want 3", grant_id); end
    request_vector = '0;
    tick();
    tick();
  endtask

  task automatic test_random;
    logic [7:0] eg;
    logic [2:0] eid;
    logic       ebf;
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 11) == 0) request_vector = 8'($urandom);
      req_last = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      resource_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 249) == 0);
      @(negedge clk);
      eg  = '0;
      eid = '0;
      ebf = 1'b0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        eid = 3'(m_owner);
        ebf = request_vector[m_owner] && resource_ready;
      end
      checks++; if (grant !== eg) begin errors++; $display("FAIL rnd_grant: cycle %0d got %h want %h", cyc, grant, eg); end
      checks++; if (grant_id !== eid) begin errors++; $display("FAIL rnd_grant_id: cycle %0d got %0d want %0d", cyc, grant_id, eid); end
      checks++; if (beat_fire !== ebf) begin errors++; $display("FAIL rnd_beat_fire: cycle %0d got %b want %b", cyc, beat_fire, ebf); end
      checks++; if (timeout_release !== m_tmo) begin errors++; $display("FAIL rnd_timeout: cycle %0d got %b want %b", cyc, timeout_release, m_tmo); end
      m_step(rst, request_vector, req_last, resource_ready);
      tick();
    end
    rst = 1'b0;
    request_vector = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ready_toggle();
    test_timeout();
    test_abandon();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
